// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// register-index width and the hard-wired zero register.
package pipe_hazard_ctrl_pkg;

   localparam int REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ABORT    = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_detect.sv
// Purely combinational hazard detection and priority resolution:
// memory wait beats a taken branch, and a taken branch beats load-use.
import pipe_hazard_ctrl_pkg::*;

module hazard_detect (
   input  logic [REG_IDX_W-1:0] rs1_d,
   input  logic [REG_IDX_W-1:0] rs2_d,
   input  logic [REG_IDX_W-1:0] rd_e,
   input  logic                 load_e,
   input  logic                 reg_wen_e,
   input  logic                 br_taken_e,
   input  logic                 mem_req_m,
   input  logic                 mem_ready,
   input  logic                 in_abort,
   output logic                 mwait,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 stall_m,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 flush_w
);

   logic lu;

   assign mwait = mem_req_m & ~mem_ready & ~in_abort;
   assign lu    = load_e & reg_wen_e & (rd_e != ZERO_REG) &
                  ((rd_e == rs1_d) | (rd_e == rs2_d));

   // While memory is waiting the whole pipe freezes, so EX keeps presenting
   // the branch or load and it is acted on once the wait ends.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = in_abort;
      if (mwait) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (br_taken_e) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (lu) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline with a data-memory
// watchdog. Define PIPE_HAZARD_CTRL_PERF_EN to add stall/flush counters.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] rs1_d,
   input  logic [REG_IDX_W-1:0] rs2_d,
   input  logic [REG_IDX_W-1:0] rd_e,
   input  logic                 load_e,
   input  logic                 reg_wen_e,
   input  logic                 br_taken_e,
   input  logic                 mem_req_m,
   input  logic                 mem_ready,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 stall_m,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 flush_w,
   output logic                 mem_abort,
   output logic                 mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]          stall_cycles,
   output logic [31:0]          flush_count
`endif
);

   localparam int WCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

   state_t            state;
   logic [WCNT_W-1:0] wcnt;
   logic              mwait;

   hazard_detect u_detect (
      .rs1_d      (rs1_d),
      .rs2_d      (rs2_d),
      .rd_e       (rd_e),
      .load_e     (load_e),
      .reg_wen_e  (reg_wen_e),
      .br_taken_e (br_taken_e),
      .mem_req_m  (mem_req_m),
      .mem_ready  (mem_ready),
      .in_abort   (state == ABORT),
      .mwait      (mwait),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .stall_e    (stall_e),
      .stall_m    (stall_m),
      .flush_d    (flush_d),
      .flush_e    (flush_e),
      .flush_w    (flush_w)
   );

   // wcnt counts stalled cycles including the one spent in RUN, so reaching
   // TIMEOUT-1 in MEM_WAIT means this is the TIMEOUT-th stalled cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         wcnt      <= '0;
         mem_abort <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         mem_abort <= 1'b0;
         mem_err   <= 1'b0;
         case (state)
            RUN: begin
               if (mwait) begin
                  state <= MEM_WAIT;
                  wcnt  <= WCNT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (mem_ready || !mem_req_m) begin
                  state <= RUN;
                  wcnt  <= '0;
               end else if (wcnt == WCNT_LAST) begin
                  state     <= ABORT;
                  wcnt      <= '0;
                  mem_abort <= 1'b1;
                  mem_err   <= 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            ABORT: begin
               state <= RUN;
            end
            default: begin
               state <= RUN;
               wcnt  <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_f) stall_cycles <= stall_cycles + 32'd1;
         if (flush_e) flush_count  <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT = 4).
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] rs1_d, rs2_d, rd_e;
   logic       load_e, reg_wen_e, br_taken_e, mem_req_m, mem_ready;
   logic       stall_f, stall_d, stall_e, stall_m;
   logic       flush_d, flush_e, flush_w, mem_abort, mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int checks = 0;
   int errors = 0;

   // Expected-vector layout: {sf,sd,se,sm,fd,fe,fw,abort,err}
   localparam logic [8:0] IDLE  = 9'b000000000;
   localparam logic [8:0] LU    = 9'b110001000;
   localparam logic [8:0] BR    = 9'b000011000;
   localparam logic [8:0] MWAIT = 9'b111100100;
   localparam logic [8:0] ABRT  = 9'b000000111;

   pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .rs1_d      (rs1_d),
      .rs2_d      (rs2_d),
      .rd_e       (rd_e),
      .load_e     (load_e),
      .reg_wen_e  (reg_wen_e),
      .br_taken_e (br_taken_e),
      .mem_req_m  (mem_req_m),
      .mem_ready  (mem_ready),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .stall_e    (stall_e),
      .stall_m    (stall_m),
      .flush_d    (flush_d),
      .flush_e    (flush_e),
      .flush_w    (flush_w),
      .mem_abort  (mem_abort),
      .mem_err    (mem_err)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic ld,
                                input logic wen, input logic br,
                                input logic req, input logic rdy);
      @(negedge clk);
      rs1_d = rs1; rs2_d = rs2; rd_e = rd;
      load_e = ld; reg_wen_e = wen; br_taken_e = br;
      mem_req_m = req; mem_ready = rdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [8:0] expected);
      logic [8:0] observed;
      observed = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                  flush_w, mem_abort, mem_err};
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %b expected %b", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1;
      rs1_d = '0; rs2_d = '0; rd_e = '0;
      load_e = 1'b0; reg_wen_e = 1'b0; br_taken_e = 1'b0;
      mem_req_m = 1'b0; mem_ready = 1'b0;
      #1;
      checkOutput("reset_idle", IDLE);
      @(negedge clk);
      rst = 1'b0;

      // Load-use on rs1 lasts one cycle, then EX holds the bubble.
      applyStimulus(5'd5, 5'd9, 5'd5, 1, 1, 0, 0, 0);
      checkOutput("lu_rs1", LU);
      applyStimulus(5'd5, 5'd9, 5'd5, 0, 0, 0, 0, 0);
      checkOutput("lu_bubble", IDLE);
      applyStimulus(5'd3, 5'd7, 5'd7, 1, 1, 0, 0, 0);
      checkOutput("lu_rs2", LU);
      applyStimulus(5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
      checkOutput("lu_x0", IDLE);
      applyStimulus(5'd5, 5'd9, 5'd5, 1, 0, 0, 0, 0);
      checkOutput("lu_nowen", IDLE);

      // Taken branch suppresses a coincident load-use.
      applyStimulus(5'd5, 5'd9, 5'd5, 1, 1, 1, 0, 0);
      checkOutput("br_over_lu", BR);
      applyStimulus(5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0);
      checkOutput("br_alone", BR);

      // Three wait cycles stall exactly three cycles.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0);
         checkOutput($sformatf("mwait3_%0d", i), MWAIT);
      end
      applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1);
      checkOutput("mwait3_done", IDLE);
      applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
      checkOutput("mwait3_run", IDLE);
      applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1);
      checkOutput("zero_wait", IDLE);

      // Wait hides a branch and load-use until mem_ready rises.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(5'd5, 5'd9, 5'd5, 1, 1, 1, 1, 0);
         checkOutput($sformatf("mwait_br_%0d", i), MWAIT);
      end
      applyStimulus(5'd5, 5'd9, 5'd5, 1, 1, 1, 1, 1);
      checkOutput("mwait_br_release", BR);

      // Watchdog: four stalled cycles, one abort cycle, then RUN.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0);
         checkOutput($sformatf("wd_stall_%0d", i), MWAIT);
      end
      applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0);
      checkOutput("wd_abort", ABRT);
      applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
      checkOutput("wd_after", IDLE);

      // Reset at wcnt = 2 restarts the watchdog from scratch.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0);
         checkOutput($sformatf("rst_pre_%0d", i), MWAIT);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rst_midwait", MWAIT);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      checks++;
      assert (stall_cycles === 32'd0 && flush_count === 32'd0)
      else begin
         errors++;
         $error("[TB] FAIL perf_rst observed %0d/%0d expected 0/0",
                stall_cycles, flush_count);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_release", MWAIT);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0);
         checkOutput($sformatf("rst_wd_%0d", i), MWAIT);
      end
      applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0);
      checkOutput("rst_wd_abort", ABRT);
      applyStimulus(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
      checkOutput("rst_wd_after", IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It watches the decode operands, the instruction in execute and the data-memory handshake of the memory stage. From these it drives hold and bubble controls into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits, and includes a watchdog that aborts a memory access that never completes.

## Interface
- TIMEOUT, 16: maximum MEM_WAIT cycles before abort; legal range 2..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs1_d  in  5  rs1 index of the instruction in decode.
- rs2_d  in  5  rs2 index of the instruction in decode.
- rd_e  in  5  destination index of the instruction in execute.
- load_e  in  1  instruction in execute is a load.
- reg_wen_e  in  1  instruction in execute writes the register file.
- br_taken_e  in  1  branch or jump resolved taken in execute.
- mem_req_m  in  1  memory stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_f  out  1  hold the PC.
- stall_d  out  1  hold IF/ID.
- stall_e  out  1  hold ID/EX.
- stall_m  out  1  hold EX/MEM.
- flush_d  out  1  clear IF/ID to a NOP.
- flush_e  out  1  clear ID/EX to a NOP.
- flush_w  out  1  insert a bubble into MEM/WB.
- mem_abort  out  1  registered; tells memory to drop the outstanding access.
- mem_err  out  1  registered; one-cycle pulse when the watchdog fires.

## Operation
- FSM states: RUN, MEM_WAIT, ABORT. Wait counter wcnt is $clog2(TIMEOUT+1) bits wide.
- mwait is mem_req_m & ~mem_ready & (state != ABORT).
- lu is load_e & reg_wen_e & (rd_e != 0) & ((rd_e == rs1_d) | (rd_e == rs2_d)).
- Priority order: memory wait, then branch, then load-use.
  - mwait = 1: stall_f = stall_d = stall_e = stall_m = 1 and flush_w = 1. flush_d = flush_e = 0. br_taken_e and lu are ignored; they remain visible because EX is held.
  - Otherwise br_taken_e = 1: flush_d = flush_e = 1 and all stalls 0. lu is suppressed because the decode instruction is on the wrong path.
  - Otherwise lu = 1: stall_f = stall_d = 1 and flush_e = 1.
  - Otherwise every control is 0.
- RUN to MEM_WAIT when mwait = 1; wcnt is loaded with 1.
- In MEM_WAIT:
  - mem_ready = 1: return to RUN and clear wcnt.
  - Else if wcnt == TIMEOUT-1: go to ABORT.
  - Else increment wcnt.
- ABORT lasts exactly one cycle:
  - mem_abort = 1 and mem_err = 1 during that cycle.
  - Stalls are released and flush_w = 1, so the faulted access retires as a bubble.
  - The next state is always RUN.
- If mem_req_m drops during MEM_WAIT without mem_ready, return to RUN and clear wcnt.

## Timing
- Stall and flush outputs are combinational from the inputs and the current state, and take effect at the same edge.
- Load-use costs exactly one bubble: lu clears the next cycle because ID/EX then holds a NOP.
- Branch penalty is 2 cycles (flush_d and flush_e on one edge).
- A memory access with N wait cycles stalls for exactly N cycles. Zero-wait accesses (mem_ready high on the request cycle) never stall.
- The watchdog fires after TIMEOUT stalled cycles. mem_abort and mem_err assert in cycle TIMEOUT+1 relative to the first stalled cycle.
- Under rst: state is RUN, wcnt = 0, mem_abort = 0, mem_err = 0. Stall and flush outputs follow their combinational equations from the inputs.
- If rst is asserted mid-MEM_WAIT, the FSM returns to RUN immediately. mem_abort is not issued; memory must be reset by the same rst.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: adds two 32-bit output ports.
  - stall_cycles counts every cycle with stall_f = 1.
  - flush_count counts every cycle with flush_e = 1.
  - Both counters wrap at 2^32 and clear on rst.
- PIPE_HAZARD_CTRL_PERF_EN undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared pipeline package holds:
  - the state enum (RUN = 0, MEM_WAIT = 1, ABORT = 2);
  - register-index width 5;
  - the zero-register constant 5'd0.
- One sub-module, hazard_detect: the purely combinational lu and priority logic. The FSM, watchdog and counters stay in the top.

## Test plan
- Load-use: load_e = 1, reg_wen_e = 1, rd_e = 5, rs1_d = 5 -> stall_f = stall_d = flush_e = 1 for exactly one cycle. With rd_e = 0 -> no stall.
- Branch over hazard: br_taken_e = 1 with the lu condition true -> flush_d = flush_e = 1, stall_f = 0.
- Memory wait: mem_req_m = 1, mem_ready low 3 cycles then high -> all four stalls plus flush_w for exactly 3 cycles, then RUN.
- Watchdog: TIMEOUT = 4, mem_ready held 0 -> 4 stalled cycles, then one cycle with mem_abort = mem_err = 1, then RUN with stalls 0.
- Simultaneous events: mem wait plus br_taken_e -> no flush during the wait; flush_d = flush_e = 1 on the cycle mem_ready rises.
- Reset mid-wait: rst pulsed at wcnt = 2 -> state RUN, wcnt = 0, no mem_err. With PIPE_HAZARD_CTRL_PERF_EN, both counters read 0.
